// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, functs, ALU ops, mux selects.
package multi_cycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_JALR = 6'h09;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;

  // Mux select encodings
  localparam logic [SEL_W-1:0] SRCA_PC      = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_REG     = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_SHAMT   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [SEL_W-1:0] REGDST_RT    = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD    = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA    = 2'b10;
  localparam logic [SEL_W-1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR      = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC       = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_REGA   = 2'b11;

  // Shift-by-shamt R-type instructions take operand A from the shamt field
  function automatic logic is_shift(input logic [FUNCT_W-1:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  // Immediate ALU instructions that write back through WB
  function automatic logic is_i_arith(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Opcodes that the controller executes; anything else retires as a NOP
  function automatic logic is_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW: return 1'b1;
      default:                                             return is_i_arith(op);
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_decode.sv
// Combinational ALU operation and immediate-extension decode from OpCode/Funct.
module alu_op_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    i_opcode,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_ext_op
);

  // ALU operation: funct-driven for R-type, opcode-driven otherwise
  always_comb begin
    o_alu_op = ALU_ADD;
    if (i_opcode == OP_RTYPE) begin
      case (i_funct)
        FN_ADD, FN_ADDU: o_alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: o_alu_op = ALU_SUB;
        FN_AND:          o_alu_op = ALU_AND;
        FN_OR:           o_alu_op = ALU_OR;
        FN_XOR:          o_alu_op = ALU_XOR;
        FN_NOR:          o_alu_op = ALU_NOR;
        FN_SLT:          o_alu_op = ALU_SLT;
        FN_SLTU:         o_alu_op = ALU_SLTU;
        FN_SLL:          o_alu_op = ALU_SLL;
        FN_SRL:          o_alu_op = ALU_SRL;
        FN_SRA:          o_alu_op = ALU_SRA;
        default:         o_alu_op = ALU_ADD;
      endcase
    end else begin
      case (i_opcode)
        OP_BEQ, OP_BNE: o_alu_op = ALU_SUB;
        OP_SLTI:        o_alu_op = ALU_SLT;
        OP_SLTIU:       o_alu_op = ALU_SLTU;
        OP_ANDI:        o_alu_op = ALU_AND;
        OP_ORI:         o_alu_op = ALU_OR;
        OP_XORI:        o_alu_op = ALU_XOR;
        OP_LUI:         o_alu_op = ALU_LUI;
        default:        o_alu_op = ALU_ADD;
      endcase
    end
  end

  // Logical immediates and lui are zero-extended; everything else sign-extends
  always_comb begin
    o_ext_op = 1'b1;
    case (i_opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_ext_op = 1'b0;
      default:                          o_ext_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with combinational control outputs.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    OpCode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [SEL_W-1:0]   RegDst,
  output logic [SEL_W-1:0]   MemtoReg,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [SEL_W-1:0]   PCSource,
  output logic [STATE_W-1:0] State_o
);

  state_e               r_state;
  state_e               w_next_state;
  logic [ALUOP_W-1:0]   w_dec_alu_op;
  logic                 w_dec_ext_op;
  logic                 w_pc_write;
  logic                 w_ir_write;
  logic                 w_mem_read;

  alu_op_decode u_alu_op_decode (
    .i_opcode (OpCode),
    .i_funct  (Funct),
    .o_alu_op (w_dec_alu_op),
    .o_ext_op (w_dec_ext_op)
  );

  // State register; reset returns to fetch asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next_state;
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = S_IF;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    IorD         = 1'b0;
    RegDst       = REGDST_RT;
    MemtoReg     = M2R_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    ExtOp        = 1'b0;
    ALUOp        = ALU_ADD;
    PCSource     = PCSRC_ALU;
    case (r_state)
      S_IF: begin
        w_mem_read   = 1'b1;
        w_ir_write   = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_ID;
      end
      S_ID: begin
        // Branch target is precomputed into ALUOut while decoding
        ALUSrcB = SRCB_IMM_SH2;
        ExtOp   = 1'b1;
        if (OpCode == OP_J) begin
          PCSource   = PCSRC_JUMP;
          w_pc_write = 1'b1;
        end else if (OpCode == OP_JAL) begin
          PCSource   = PCSRC_JUMP;
          w_pc_write = 1'b1;
          RegWrite   = 1'b1;
          RegDst     = REGDST_RA;
          MemtoReg   = M2R_PC;
        end else if (is_supported(OpCode)) begin
          w_next_state = S_EX;
        end
      end
      S_EX: begin
        ALUOp = w_dec_alu_op;
        ExtOp = w_dec_ext_op;
        if (OpCode == OP_RTYPE) begin
          ALUSrcB = SRCB_REG;
          if (Funct == FN_JR) begin
            ALUSrcA    = SRCA_REG;
            PCSource   = PCSRC_REGA;
            w_pc_write = 1'b1;
          end else if (Funct == FN_JALR) begin
            ALUSrcA    = SRCA_REG;
            PCSource   = PCSRC_REGA;
            w_pc_write = 1'b1;
            RegWrite   = 1'b1;
            RegDst     = REGDST_RD;
            MemtoReg   = M2R_PC;
          end else begin
            ALUSrcA      = is_shift(Funct) ? SRCA_SHAMT : SRCA_REG;
            w_next_state = S_WB;
          end
        end else if ((OpCode == OP_BEQ) || (OpCode == OP_BNE)) begin
          ALUSrcA    = SRCA_REG;
          ALUSrcB    = SRCB_REG;
          ALUOp      = ALU_SUB;
          PCSource   = PCSRC_ALUOUT;
          w_pc_write = (OpCode == OP_BEQ) ? Zero : ~Zero;
        end else if ((OpCode == OP_LW) || (OpCode == OP_SW)) begin
          ALUSrcA      = SRCA_REG;
          ALUSrcB      = SRCB_IMM;
          w_next_state = S_MEM;
        end else if (is_i_arith(OpCode)) begin
          ALUSrcA      = SRCA_REG;
          ALUSrcB      = SRCB_IMM;
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        IorD = 1'b1;
        if (OpCode == OP_LW) begin
          w_mem_read   = 1'b1;
          w_next_state = S_WB;
        end else if (OpCode == OP_SW) begin
          MemWrite = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (OpCode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
        MemtoReg = (OpCode == OP_LW) ? M2R_MDR : M2R_ALUOUT;
      end
      default: begin
        w_next_state = S_IF;
      end
    endcase
  end

  // Fetch-side strobes are held off while reset is asserted
  assign PCWrite = w_pc_write & rst_n;
  assign IRWrite = w_ir_write & rst_n;
  assign MemRead = w_mem_read & rst_n;
  assign State_o = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-instruction state sequences and control outputs.
module tb_multi_cycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [2:0] State_o;

  int checks = 0;
  int passes = 0;

  multi_cycle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .OpCode   (OpCode),
    .Funct    (Funct),
    .Zero     (Zero),
    .PCWrite  (PCWrite),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ExtOp    (ExtOp),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .State_o  (State_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (State_o !== 3'd0) $display("FAIL rst_state: got %0d, expected 0", State_o); else passes++;
    checks++; if ({PCWrite, IRWrite, MemRead} !== 3'b000) $display("FAIL rst_gated_strobes: got %b, expected 000", {PCWrite, IRWrite, MemRead}); else passes++;
    checks++; if ({ALUSrcA, ALUSrcB} !== 4'b0001) $display("FAIL rst_if_decode: got %b, expected 0001", {ALUSrcA, ALUSrcB}); else passes++;
    checks++; if ({MemWrite, RegWrite} !== 2'b00) $display("FAIL rst_wr_strobes: got %b, expected 00", {MemWrite, RegWrite}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({PCWrite, IRWrite, MemRead, IorD} !== 4'b1110) $display("FAIL if_fetch: got %b, expected 1110", {PCWrite, IRWrite, MemRead, IorD}); else passes++;
    step;
    checks++; if (State_o !== 3'd1) $display("FAIL first_fetch_state: got %0d, expected 1", State_o); else passes++;
    OpCode = 6'h3F;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL first_nop_return: got %0d, expected 0", State_o); else passes++;
  endtask

  task automatic test_add;
    OpCode = 6'h00; Funct = 6'h20;
    checks++; if (State_o !== 3'd0) $display("FAIL add_if: got %0d, expected 0", State_o); else passes++;
    step;
    checks++; if (State_o !== 3'd1) $display("FAIL add_id: got %0d, expected 1", State_o); else passes++;
    checks++; if ({ALUSrcA, ALUSrcB, ExtOp, PCWrite} !== 6'b001110) $display("FAIL add_id_ctrl: got %b, expected 001110", {ALUSrcA, ALUSrcB, ExtOp, PCWrite}); else passes++;
    step;
    checks++; if (State_o !== 3'd2) $display("FAIL add_ex: got %0d, expected 2", State_o); else passes++;
    checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== 8'b0100_0000) $display("FAIL add_ex_ctrl: got %b, expected 01000000", {ALUSrcA, ALUSrcB, ALUOp}); else passes++;
    step;
    checks++; if (State_o !== 3'd4) $display("FAIL add_wb: got %0d, expected 4", State_o); else passes++;
    checks++; if ({RegWrite, RegDst, MemtoReg} !== 5'b10100) $display("FAIL add_wb_ctrl: got %b, expected 10100", {RegWrite, RegDst, MemtoReg}); else passes++;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL add_done: got %0d, expected 0", State_o); else passes++;
  endtask

  task automatic test_sll;
    OpCode = 6'h00; Funct = 6'h00;
    step; step;
    checks++; if (State_o !== 3'd2) $display("FAIL sll_ex: got %0d, expected 2", State_o); else passes++;
    checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== 8'b1000_1000) $display("FAIL sll_ex_ctrl: got %b, expected 10001000", {ALUSrcA, ALUSrcB, ALUOp}); else passes++;
    step;
    checks++; if (State_o !== 3'd4) $display("FAIL sll_wb: got %0d, expected 4", State_o); else passes++;
    step;
  endtask

  task automatic test_lw;
    OpCode = 6'h23; Funct = 6'h15;
    step; step;
    checks++; if ({State_o, ALUSrcA, ALUSrcB, ExtOp} !== 8'b010_01_10_1) $display("FAIL lw_ex: got %b, expected 01001101", {State_o, ALUSrcA, ALUSrcB, ExtOp}); else passes++;
    step;
    checks++; if ({State_o, IorD, MemRead, MemWrite} !== 6'b011_110) $display("FAIL lw_mem: got %b, expected 011110", {State_o, IorD, MemRead, MemWrite}); else passes++;
    step;
    checks++; if ({State_o, RegWrite, MemtoReg, RegDst} !== 8'b100_1_01_00) $display("FAIL lw_wb: got %b, expected 10010100", {State_o, RegWrite, MemtoReg, RegDst}); else passes++;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL lw_done: got %0d, expected 0", State_o); else passes++;
  endtask

  task automatic test_branch;
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       exp [4];
    ops = '{6'h04, 6'h04, 6'h05, 6'h05};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      OpCode = ops[i]; Zero = zs[i];
      step;
      checks++; if (PCWrite !== 1'b0) $display("FAIL br%0d_id_pcwrite: got %b, expected 0", i, PCWrite); else passes++;
      step;
      checks++; if ({State_o, PCSource, ALUOp} !== {3'd2, 2'b01, 4'd1}) $display("FAIL br%0d_ex_ctrl: got %b, expected 010010001", i, {State_o, PCSource, ALUOp}); else passes++;
      checks++; if (PCWrite !== exp[i]) $display("FAIL br%0d_ex_pcwrite: got %b, expected %b", i, PCWrite, exp[i]); else passes++;
      step;
      checks++; if (State_o !== 3'd0) $display("FAIL br%0d_done: got %0d, expected 0", i, State_o); else passes++;
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal;
    OpCode = 6'h03;
    step;
    checks++; if ({PCWrite, RegWrite, RegDst, MemtoReg, PCSource} !== 8'b11_10_10_10) $display("FAIL jal_id: got %b, expected 11101010", {PCWrite, RegWrite, RegDst, MemtoReg, PCSource}); else passes++;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL jal_done: got %0d, expected 0", State_o); else passes++;
  endtask

  task automatic test_jr;
    OpCode = 6'h00; Funct = 6'h08;
    step; step;
    checks++; if ({PCWrite, PCSource, RegWrite} !== 4'b1110) $display("FAIL jr_ex: got %b, expected 1110", {PCWrite, PCSource, RegWrite}); else passes++;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL jr_done: got %0d, expected 0", State_o); else passes++;
  endtask

  task automatic test_andi;
    OpCode = 6'h0C;
    step; step;
    checks++; if ({ExtOp, ALUSrcB, ALUOp} !== 7'b0_10_0010) $display("FAIL andi_ex: got %b, expected 0100010", {ExtOp, ALUSrcB, ALUOp}); else passes++;
    step;
    checks++; if ({State_o, RegDst} !== 5'b100_00) $display("FAIL andi_wb: got %b, expected 10000", {State_o, RegDst}); else passes++;
    step;
  endtask

  task automatic test_reset_mid_sw;
    OpCode = 6'h2B;
    step; step; step;
    checks++; if ({State_o, IorD, MemWrite, MemRead} !== 6'b011_110) $display("FAIL sw_mem: got %b, expected 011110", {State_o, IorD, MemWrite, MemRead}); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({State_o, MemWrite} !== 4'b000_0) $display("FAIL sw_rst_abort: got %b, expected 0000", {State_o, MemWrite}); else passes++;
    checks++; if ({PCWrite, IRWrite, MemRead, RegWrite} !== 4'b0000) $display("FAIL sw_rst_strobes: got %b, expected 0000", {PCWrite, IRWrite, MemRead, RegWrite}); else passes++;
    OpCode = 6'h3F;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL rst_hold_state: got %0d, expected 0", State_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({State_o, MemWrite, PCWrite} !== 5'b000_01) $display("FAIL post_rst_if: got %b, expected 00001", {State_o, MemWrite, PCWrite}); else passes++;
    step;
    checks++; if (State_o !== 3'd1) $display("FAIL nop_id: got %0d, expected 1", State_o); else passes++;
    checks++; if ({PCWrite, IRWrite, RegWrite, MemRead, MemWrite} !== 5'b00000) $display("FAIL nop_strobes: got %b, expected 00000", {PCWrite, IRWrite, RegWrite, MemRead, MemWrite}); else passes++;
    step;
    checks++; if (State_o !== 3'd0) $display("FAIL nop_done: got %0d, expected 0", State_o); else passes++;
  endtask

  initial begin
    rst_n  = 1'b0;
    OpCode = 6'h00;
    Funct  = 6'h00;
    Zero   = 1'b0;
    test_reset;
    test_add;
    test_sll;
    test_lw;
    test_branch;
    test_jal;
    test_jr;
    test_andi;
    test_reset_mid_sw;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
